arbiter_n: RTL



---
 rtl/arbiter_pkg.sv | 23 ++
 rtl/arbiter_prio_picker.sv | 40 ++++
 rtl/arbiter_n.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the N-requester arbiter.
// Holds the policy/state enums and the one-hot to binary encoder used for gnt_id.
package arbiter_pkg;

   typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
   typedef enum logic {IDLE, GRANT} arb_state_e;

   localparam int unsigned ARB_MAX_N = 16;
   localparam int unsigned ARB_ID_W  = 4;

   // OR-reduction encoder; input is assumed one-hot or zero
   function automatic logic [ARB_ID_W-1:0] onehot2bin(input logic [ARB_MAX_N-1:0] oh);
      logic [ARB_ID_W-1:0] bin;
      bin = '0;
      for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
         if (oh[i]) begin
            bin = bin | ARB_ID_W'(i);
         end
      end
      return bin;
   endfunction

endpackage

// File: rtl/arbiter_prio_picker.sv
// Combinational circular priority picker: first unmasked request at or after ptr.
// With ptr tied to zero it degenerates into a lowest-index fixed-priority picker.
module prio_picker
   import arbiter_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick_c,
   output logic          any_c
);

   logic [N-1:0] cand;
   logic         found;

   // Walk ptr, ptr+1, ... with an explicit wrap so non-power-of-two N stays in range
   always_comb begin
      cand   = req & ~mask;
      pick_c = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         int unsigned    idx;
         logic [PW-1:0]  sel;
         idx = 32'(ptr) + i;
         if (idx >= N) begin
            idx = idx - N;
         end
         sel = PW'(idx);
         if (!found && cand[sel]) begin
            pick_c[sel] = 1'b1;
            found       = 1'b1;
         end
      end
      any_c = |cand;
   end

endmodule

// File: rtl/arbiter_n.sv
// N-requester arbiter with registered one-hot grant, fixed or round-robin policy,
// and an optional forced hand-over after MAX_HOLD consecutive grant cycles.
module arbiter_n
   import arbiter_pkg::*;
#(
   parameter int unsigned N        = 3,
   parameter arb_mode_e   MODE     = ARB_RR,
   parameter int unsigned MAX_HOLD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   // Counter stops at the timeout threshold so a late competitor still triggers hand-over
   localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

   arb_state_e    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic          valid_q, valid_d;
   logic [IW-1:0] id_q, id_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] hold_q, hold_d;

   logic          holder_req_c;
   logic          others_c;
   logic          timeout_c;
   logic          issue_c;
   logic [N-1:0]  mask_c;
   logic [IW-1:0] start_c;
   logic [N-1:0]  pick_c;
   logic          any_c;
   logic [IW-1:0] pick_id_c;
   logic [IW-1:0] ptr_nxt_c;

   assign holder_req_c = |(req & gnt_q);
   assign others_c     = |(req & ~gnt_q);
   assign timeout_c    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_c;
   assign mask_c       = timeout_c ? gnt_q : '0;
   assign start_c      = (MODE == ARB_RR) ? ptr_q : '0;

   prio_picker #(
      .N  (N),
      .PW (IW)
   ) u_picker (
      .req    (req),
      .mask   (mask_c),
      .ptr    (start_c),
      .pick_c (pick_c),
      .any_c  (any_c)
   );

   assign pick_id_c = IW'(onehot2bin(ARB_MAX_N'(pick_c)));
   assign ptr_nxt_c = (pick_id_c == IW'(N - 1)) ? '0 : pick_id_c + IW'(1);

   // Next-state: keep, hand over, or drop to idle
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      issue_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_c) begin
               issue_c = 1'b1;
            end
         end
         GRANT: begin
            if (holder_req_c && !timeout_c) begin
               if (hold_q != HOLD_LAST) begin
                  hold_d = hold_q + CW'(1);
               end
            end else if (any_c) begin
               issue_c = 1'b1;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
               valid_d = 1'b0;
               id_d    = '0;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (issue_c) begin
         state_d = GRANT;
         gnt_d   = pick_c;
         valid_d = 1'b1;
         id_d    = pick_id_c;
         ptr_d   = ptr_nxt_c;
         hold_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = valid_q;
   assign gnt_id    = id_q;

endmodule
